// File: rtl/mul_pkg.sv
// Shared types and opcode encodings for the iterative shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_CALC,
    MUL_DONE
  } mul_state_t;

  // Opcode encodings on {in_signed, in_hi}
  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULH  = 2'b11;
  localparam logic [1:0] OP_MULHU = 2'b01;

  typedef struct packed {
    logic is_signed;
    logic is_hi;
  } mul_op_t;

  function automatic mul_op_t decode_op(logic [1:0] op);
    mul_op_t d;
    case (op)
      OP_MUL:   d = '{is_signed: 1'b0, is_hi: 1'b0};
      OP_MULH:  d = '{is_signed: 1'b1, is_hi: 1'b1};
      OP_MULHU: d = '{is_signed: 1'b0, is_hi: 1'b1};
      default:  d = '{is_signed: 1'b1, is_hi: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add multiply step: conditional accumulate, shift multiplicand left,
// shift multiplier right. b_zero flags that no set multiplier bits remain.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               b_zero
);

  assign acc_o  = b_i[0] ? (acc_i + a_i) : acc_i;
  assign a_o    = a_i << 1;
  assign b_o    = b_i >> 1;
  assign b_zero = (b_o == '0);

endmodule

// File: rtl/mul_unit_iter.sv
// Iterative shift-add multiplier (MUL/MULH/MULHU) with val/rdy handshakes.
// Optional MUL_EARLY_EXIT_EN ends CALC once the remaining multiplier is zero.
//
// state    | meaning
// ---------+------------------------------------------------------------
// MUL_IDLE | ready for operands; accept latches magnitudes, sign, half
// MUL_CALC | one multiplier bit per cycle; result registered on last step
// MUL_DONE | out_val high, out_data held until out_rdy
module mul_unit_iter
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  input  logic             in_hi,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mul_state_t state_q, state_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             hi_q, hi_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [W2-1:0]    step_acc;
  logic [W2-1:0]    step_a;
  logic [WIDTH-1:0] step_b;
  logic             step_b_zero;
  logic             last_step;
  logic [W2-1:0]    prod;
  mul_op_t          op;
  logic [WIDTH-1:0] mag_a, mag_b;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .acc_o  (step_acc),
    .a_o    (step_a),
    .b_o    (step_b),
    .b_zero (step_b_zero)
  );

  assign op    = decode_op({in_signed, in_hi});
  assign mag_a = (op.is_signed && in_a[WIDTH-1]) ? (WIDTH'(0) - in_a) : in_a;
  assign mag_b = (op.is_signed && in_b[WIDTH-1]) ? (WIDTH'(0) - in_b) : in_b;
  assign prod  = neg_q ? (W2'(0) - step_acc) : step_acc;

`ifdef MUL_EARLY_EXIT_EN
  assign last_step = step_b_zero || (cnt_q == LAST_CNT);
`else
  assign last_step = (cnt_q == LAST_CNT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MUL_IDLE;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      hi_q       <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      hi_q       <= hi_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (in_val)    state_d = MUL_CALC;
      MUL_CALC: if (last_step) state_d = MUL_DONE;
      MUL_DONE: if (out_rdy)   state_d = MUL_IDLE;
      default:                 state_d = MUL_IDLE;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    hi_d       = hi_q;
    out_data_d = out_data_q;
    case (state_q)
      MUL_IDLE: begin
        if (in_val) begin
          acc_d = '0;
          a_d   = {{WIDTH{1'b0}}, mag_a};
          b_d   = mag_b;
          cnt_d = '0;
          neg_d = op.is_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          hi_d  = op.is_hi;
        end
      end
      MUL_CALC: begin
        acc_d = step_acc;
        // Once no multiplier bits remain the multiplicand is never added again,
        // so stop it toggling.
        a_d   = step_b_zero ? a_q : step_a;
        b_d   = step_b;
        cnt_d = cnt_q + CW'(1);
        if (last_step)
          out_data_d = hi_q ? prod[W2-1:WIDTH] : prod[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    in_rdy  = (state_q == MUL_IDLE);
    out_val = (state_q == MUL_DONE);
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_mul_unit_iter.sv
// Directed bench for mul_unit_iter (WIDTH=32) with an expected-result scoreboard.
module tb_mul_unit_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_val;
  logic         in_rdy;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_signed;
  logic         in_hi;
  logic         out_val;
  logic         out_rdy;
  logic [W-1:0] out_data;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] sb[$];

  mul_unit_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_hi     (in_hi),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic h);
    logic [2*W-1:0] p;
    if (s) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    else   p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return h ? p[2*W-1:W] : p[W-1:0];
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b, input logic s);
`ifdef MUL_EARLY_EXIT_EN
    logic [W-1:0] mag;
    int n;
    mag = (s && b[W-1]) ? (~b + 1'b1) : b;
    n = 0;
    for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
    if (n == 0) n = 1;
    return n + 1;
`else
    return (s || !s) ? W + 1 : 0;
`endif
  endfunction

  // Drives one op from IDLE through handoff; bp = cycles of out_rdy=0 in DONE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic h, input int bp);
    int cyc;
    logic [W-1:0] held;
    logic [W-1:0] exp;
    check({tag, "_in_rdy_idle"}, W'(in_rdy), W'(1));
    in_val = 1'b1; in_a = a; in_b = b; in_signed = s; in_hi = h;
    sb.push_back(model(a, b, s, h));
    tick();
    in_val = 1'b0; in_a = $urandom; in_b = $urandom;
    in_signed = 1'($urandom); in_hi = 1'($urandom);
    cyc = 1;
    while (!out_val && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, W'(cyc), W'(exp_lat(b, s)));
    if (!out_val) begin
      void'(sb.pop_front());
      return;
    end
    check({tag, "_in_rdy_done"}, W'(in_rdy), W'(0));
    held = out_data;
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, "_bp_hold"}, out_data, held);
      check({tag, "_bp_in_rdy"}, W'(in_rdy), W'(0));
      check({tag, "_bp_out_val"}, W'(out_val), W'(1));
    end
    out_rdy = 1'b1;
    exp = sb.pop_front();
    check({tag, "_data"}, out_data, exp);
    tick();
    out_rdy = 1'b0;
    check({tag, "_in_rdy_after"}, W'(in_rdy), W'(1));
    check({tag, "_out_val_after"}, W'(out_val), W'(0));
  endtask

  initial begin
    rst = 1'b1; in_val = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_hi = 1'b0; out_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_in_rdy", W'(in_rdy), W'(1));
    check("reset_out_val", W'(out_val), W'(0));
    check("reset_out_data", out_data, W'(0));

    run_op("mul_3x4",      32'd3,          32'd4,          1'b0, 1'b0, 0);
    run_op("mul_m5x7_lo",  32'hFFFF_FFFB,  32'd7,          1'b1, 1'b0, 0);
    run_op("mul_m5x7_hi",  32'hFFFF_FFFB,  32'd7,          1'b1, 1'b1, 0);
    run_op("mulhu_ff",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b1, 0);
    run_op("mul_ff_lo",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 0);
    run_op("mulh_min",     32'h8000_0000,  32'h8000_0000,  1'b1, 1'b1, 0);
    run_op("mul_zero",     32'd0,          32'h1234_5678,  1'b0, 1'b0, 0);
    run_op("mul_b_zero",   32'h1234_5678,  32'd0,          1'b1, 1'b1, 0);
    run_op("mulh_neg_b",   32'h7FFF_FFFF,  32'h8000_0001,  1'b1, 1'b1, 0);
    run_op("bp_op",        32'h0001_2345,  32'h0000_6789,  1'b0, 1'b1, 5);
    run_op("after_bp",     32'd2,          32'd3,          1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      run_op("rand", $urandom, $urandom, 1'($urandom), 1'($urandom), i);

    // Reset in CALC cycle 10 discards the op.
    check("midrst_in_rdy_idle", W'(in_rdy), W'(1));
    in_val = 1'b1; in_a = 32'd5; in_b = 32'h8000_0001; in_signed = 1'b0; in_hi = 1'b0;
    sb.push_back(model(in_a, in_b, in_signed, in_hi));
    tick();
    in_val = 1'b0;
    repeat (9) tick();
    check("midrst_busy_in_rdy", W'(in_rdy), W'(0));
    check("midrst_busy_out_val", W'(out_val), W'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_front());
    check("midrst_in_rdy", W'(in_rdy), W'(1));
    check("midrst_out_val", W'(out_val), W'(0));
    check("midrst_out_data", out_data, W'(0));
    run_op("mul_6x7", 32'd6, 32'd7, 1'b0, 1'b0, 0);
    check("sb_empty", W'(sb.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
